// File: rtl/nibble_sum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  nibble_acc_pkg
//  Shared types and helpers for the nibble sum accumulator.
//  Revision: 1.0
// ============================================================================
package nibble_acc_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Counter width able to represent 0..count inclusive
   function automatic int cnt_w(input int count);
      return $clog2(count + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_sum_accumulator_sat_adder.sv
`default_nettype none
// ============================================================================
//  sat_adder
//  Combinational saturating add of a SUM_W sample into an ACC_W total.
//  Revision: 1.0
// ============================================================================
module sat_adder #(
   parameter int SUM_W = 4,
   parameter int ACC_W = 8
) (
   input  logic [ACC_W-1:0] a,
   input  logic [SUM_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             clip
);

   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   logic [ACC_W:0] wide;

   // One extra bit catches the carry-out that signals overflow
   assign wide = {1'b0, a} + {{(ACC_W + 1 - SUM_W){1'b0}}, b};
   assign clip = wide[ACC_W];
   assign sum  = clip ? ACC_MAX : wide[ACC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/nibble_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  nibble_sum_accumulator
//  Accumulates COUNT samples into a saturating total plus window max/sat flag.
//  Revision: 1.0
// ============================================================================
module nibble_sum_accumulator
   import nibble_acc_pkg::*;
#(
   parameter int SUM_W = 4,
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [SUM_W-1:0] out_max,
   output logic             out_sat,
   output logic             busy
);

   localparam int               CNT_W    = cnt_w(COUNT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [SUM_W-1:0] max_q, max_d;
   logic             sat_q, sat_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [SUM_W-1:0] out_max_q, out_max_d;
   logic             out_sat_q, out_sat_d;

   logic [ACC_W-1:0] add_sum;
   logic             add_clip;
   logic [SUM_W-1:0] add_max;

   sat_adder #(
      .SUM_W (SUM_W),
      .ACC_W (ACC_W)
   ) u_sat_adder (
      .a    (acc_q),
      .b    (in_data),
      .sum  (add_sum),
      .clip (add_clip)
   );

   assign add_max = (in_data > max_q) ? in_data : max_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      max_d     = max_q;
      sat_d     = sat_q;
      out_sum_d = out_sum_q;
      out_max_d = out_max_q;
      out_sat_d = out_sat_q;
      if (clear) begin
         state_d = ACCUM;
         cnt_d   = '0;
         acc_d   = '0;
         max_d   = '0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  if (cnt_q == LAST_CNT) begin
                     // Final sample goes straight into the result, window restarts empty
                     out_sum_d = add_sum;
                     out_max_d = add_max;
                     out_sat_d = sat_q | add_clip;
                     cnt_d     = '0;
                     acc_d     = '0;
                     max_d     = '0;
                     sat_d     = 1'b0;
                     state_d   = HOLD;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                     acc_d = add_sum;
                     max_d = add_max;
                     sat_d = sat_q | add_clip;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ACCUM;
         cnt_q     <= '0;
         acc_q     <= '0;
         max_q     <= '0;
         sat_q     <= 1'b0;
         out_sum_q <= '0;
         out_max_q <= '0;
         out_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         max_q     <= max_d;
         sat_q     <= sat_d;
         out_sum_q <= out_sum_d;
         out_max_q <= out_max_d;
         out_sat_q <= out_sat_d;
      end
   end

   // Ready is withheld while reset is asserted so producers never see a phantom slot
   assign in_ready  = (state_q == ACCUM) && !reset;
   assign out_valid = (state_q == HOLD);
   assign out_sum   = out_sum_q;
   assign out_max   = out_max_q;
   assign out_sat   = out_sat_q;
   assign busy      = (state_q == HOLD) || (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_nibble_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  tb_nibble_sum_accumulator
//  Directed vectors plus a randomised window scoreboard for the accumulator.
//  Revision: 1.0
// ============================================================================
module tb_nibble_sum_accumulator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = '0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, out_sat, busy;
   logic [7:0] out_sum;
   logic [3:0] out_max;

   logic       clear_b = 1'b0;
   logic       in_valid_b = 1'b0;
   logic [3:0] in_data_b = '0;
   logic       out_ready_b = 1'b1;
   logic       in_ready_b, out_valid_b, out_sat_b, busy_b;
   logic [7:0] out_sum_b;
   logic [3:0] out_max_b;

   int n_chk = 0;
   int n_bad = 0;

   nibble_sum_accumulator #(.SUM_W(4), .ACC_W(8), .COUNT(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_max   (out_max),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   nibble_sum_accumulator #(.SUM_W(4), .ACC_W(8), .COUNT(20)) u_dut20 (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_b),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .in_data   (in_data_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .out_sum   (out_sum_b),
      .out_max   (out_max_b),
      .out_sat   (out_sat_b),
      .busy      (busy_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   logic [3:0] v1 [4] = '{4'd3, 4'd5, 4'd7, 4'd1};

   // Scoreboard state for the randomised section
   int          exp_sum [$];
   int          exp_max [$];
   int          exp_sat [$];
   int          w_acc, w_max, w_n, sent, got, cyc;
   logic [3:0]  d_r;

   initial begin
      // Reset values while reset is held
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_sum", 32'(out_sum), 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // 3,5,7,1 back-to-back
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         feed(v1[i]);
         if (i < 3) chk("w1_no_valid_early", 32'(out_valid), 0);
      end
      chk("w1_out_valid", 32'(out_valid), 1);
      chk("w1_out_sum", 32'(out_sum), 16);
      chk("w1_out_max", 32'(out_max), 7);
      chk("w1_out_sat", 32'(out_sat), 0);
      chk("w1_in_ready_hold", 32'(in_ready), 0);
      tick();
      chk("w1_valid_drop", 32'(out_valid), 0);
      chk("w1_ready_back", 32'(in_ready), 1);
      chk("w1_busy_idle", 32'(busy), 0);

      // Result stalled for 10 cycles while the producer keeps pushing
      out_ready = 1'b0;
      repeat (4) feed(4'd15);
      in_valid = 1'b1;
      in_data  = 4'd9;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_in_ready", 32'(in_ready), 0);
         chk("hold_sum", 32'(out_sum), 60);
      end
      chk("hold_max", 32'(out_max), 15);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("hold_release_valid", 32'(out_valid), 0);
      chk("hold_release_ready", 32'(in_ready), 1);
      chk("hold_nothing_taken", 32'(busy), 0);
      chk("hold_sum_retained", 32'(out_sum), 60);

      // Partial window dropped by clear
      feed(4'd9);
      feed(4'd9);
      chk("clr_busy_before", 32'(busy), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy_after", 32'(busy), 0);
      repeat (4) feed(4'd1);
      chk("clr_out_valid", 32'(out_valid), 1);
      chk("clr_out_sum", 32'(out_sum), 4);
      chk("clr_out_max", 32'(out_max), 1);
      tick();

      // Asynchronous reset while a result is held
      out_ready = 1'b0;
      feed(4'd2); feed(4'd3); feed(4'd4); feed(4'd5);
      chk("rh_valid_before", 32'(out_valid), 1);
      #2 reset = 1'b1;
      #1;
      chk("rh_out_valid", 32'(out_valid), 0);
      chk("rh_in_ready", 32'(in_ready), 0);
      chk("rh_busy", 32'(busy), 0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rh_ready_after", 32'(in_ready), 1);
      out_ready = 1'b1;
      repeat (4) feed(4'd2);
      chk("rh_out_valid2", 32'(out_valid), 1);
      chk("rh_out_sum2", 32'(out_sum), 8);
      tick();

      // COUNT=20 saturation: 20*15=300 clips at 255
      for (int i = 0; i < 20; i++) begin
         in_valid_b = 1'b1;
         in_data_b  = 4'd15;
         tick();
      end
      in_valid_b = 1'b0;
      chk("c20_out_valid", 32'(out_valid_b), 1);
      chk("c20_out_sum", 32'(out_sum_b), 255);
      chk("c20_out_sat", 32'(out_sat_b), 1);
      chk("c20_out_max", 32'(out_max_b), 15);
      tick();
      chk("c20_busy_idle", 32'(busy_b), 0);

      // Random gaps and stalls across 200 windows
      w_acc = 0; w_max = 0; w_n = 0; sent = 0; got = 0; cyc = 0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      while (got < 200 && cyc < 20000) begin
         if (!in_valid || in_ready) begin
            in_valid = (sent < 800) && ($urandom_range(0, 3) != 0);
            d_r      = 4'($urandom_range(0, 15));
            in_data  = d_r;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         if (in_valid && in_ready) begin
            sent++;
            w_acc += int'(in_data);
            if (int'(in_data) > w_max) w_max = int'(in_data);
            w_n++;
            if (w_n == 4) begin
               exp_sum.push_back(w_acc > 255 ? 255 : w_acc);
               exp_max.push_back(w_max);
               exp_sat.push_back(w_acc > 255 ? 1 : 0);
               w_acc = 0; w_max = 0; w_n = 0;
            end
         end
         if (out_valid && out_ready) begin
            got++;
            if (exp_sum.size() == 0) begin
               chk("rnd_unexpected_result", 32'(got), 32'(0));
            end else begin
               chk("rnd_sum", 32'(out_sum), 32'(exp_sum.pop_front()));
               chk("rnd_max", 32'(out_max), 32'(exp_max.pop_front()));
               chk("rnd_sat", 32'(out_sat), 32'(exp_sat.pop_front()));
            end
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("rnd_windows", 32'(got), 200);
      chk("rnd_samples", 32'(sent), 800);
      chk("rnd_leftover", 32'(exp_sum.size()), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
